// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the instruction boot loader.
`default_nettype none

package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CHK   = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

  localparam int DEFAULT_MEM_SIZE = 1024;
  localparam int CSUM_W           = 8;

endpackage

`default_nettype wire

// File: rtl/instr_word_assembler.sv
// instr_word_assembler: packs four stream bytes little-endian into a word
// and keeps a running XOR checksum of every byte shifted in.
`default_nettype none

module instr_word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift,
  input  logic [7:0]        byte_in,
  output logic [31:0]       word,
  output logic [CSUM_W-1:0] csum,
  output logic              word_full
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      word     <= 32'd0;
      csum     <= '0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      csum     <= '0;
    end else if (shift) begin
      byte_cnt <= byte_cnt + 2'd1;
      // Newest byte enters at the top so byte 0 ends up in bits [7:0].
      word     <= {byte_in, word[31:8]};
      csum     <= csum ^ byte_in;
    end
  end

  assign word_full = shift && (byte_cnt == 2'd3);

endmodule

`default_nettype wire

// File: rtl/instr_loader.sv
// instr_loader: receives a length-prefixed, XOR-checksummed byte stream and
// writes it word-by-word into instruction RAM, holding the CPU until it is valid.
`default_nettype none

module instr_loader
  import loader_pkg::*;
#(
  parameter int MEM_SIZE = DEFAULT_MEM_SIZE,
  parameter int ADDR_W   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  localparam int MAX_WORDS = MEM_SIZE / 4;

  generate
    if (MEM_SIZE <= 4 || (MEM_SIZE & (MEM_SIZE - 1)) != 0) begin : g_bad_mem_size
      $error("instr_loader: MEM_SIZE must be a power of two greater than 4");
    end
  endgenerate

  state_t state, state_nx;

  logic [15:0]       len;
  logic [15:0]       word_idx;
  logic [15:0]       idx_inc;
  logic [15:0]       len_full;
  logic              fire;
  logic              load_start;
  logic [31:0]       asm_word;
  logic [CSUM_W-1:0] asm_csum;
  logic              word_full;

  assign fire       = in_valid && in_ready;
  assign load_start = start && (state == IDLE || state == DONE || state == ERR);
  assign len_full   = {in_data, len[7:0]};
  assign idx_inc    = word_idx + 16'd1;

  instr_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (load_start),
    .shift     (fire && state == DATA),
    .byte_in   (in_data),
    .word      (asm_word),
    .csum      (asm_csum),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len      <= 16'd0;
      word_idx <= 16'd0;
    end else begin
      if (load_start)            word_idx   <= 16'd0;
      if (fire && state == LEN0) len[7:0]   <= in_data;
      if (fire && state == LEN1) len[15:8]  <= in_data;
      if (state == WRITE)        word_idx   <= idx_inc;
    end
  end

  assign wr_addr = {{(ADDR_W-18){1'b0}}, word_idx, 2'b00};
  assign wr_data = asm_word;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state)
      IDLE: if (start) state_nx = LEN0;
      LEN0: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nx = LEN1;
      end
      LEN1: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if ({16'd0, len_full} > 32'(MAX_WORDS)) state_nx = ERR;
          else if (len_full == 16'd0)             state_nx = CHK;
          else                                    state_nx = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (word_full) state_nx = WRITE;
      end
      WRITE: begin
        wr_en    = 1'b1;
        busy     = 1'b1;
        state_nx = (idx_inc == len) ? CHK : DATA;
      end
      CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nx = (in_data == asm_csum) ? DONE : ERR;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nx = LEN0;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_nx = LEN0;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// tb_instr_loader: drives length/data/checksum streams into instr_loader and
// compares RAM writes and final status against a stream-level reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_instr_loader;

  localparam int MEM_SIZE = 1024;
  localparam int ADDR_W   = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_hold;

  instr_loader #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  stream[$];
  logic [63:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_ok;
  int          n_send;
  logic        prev_wr_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: decode the whole stream into the writes it implies.
  function automatic void build_model();
    int          n;
    logic [7:0]  cs;
    logic [31:0] w;
    n  = int'(stream[0]) + 256 * int'(stream[1]);
    cs = 8'd0;
    exp_addr.delete();
    exp_data.delete();
    if (n > MEM_SIZE / 4) begin
      exp_ok = 1'b0;
      n_send = 2;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++) begin
        w  = w | (32'(stream[2 + 4*i + b]) << (8*b));
        cs = cs ^ stream[2 + 4*i + b];
      end
      exp_addr.push_back(64'(i * 4));
      exp_data.push_back(w);
    end
    exp_ok = (stream[2 + 4*n] == cs);
    n_send = 3 + 4*n;
  endfunction

  always @(negedge clk) begin
    if (wr_en) begin
      check("wr_align_bounds", {63'd0, (wr_addr[1:0] == 2'b00) && (wr_addr + 3 < MEM_SIZE)}, 64'd1);
      check("wr_single_cycle", {63'd0, prev_wr_en}, 64'd0);
      if (exp_addr.size() == 0) begin
        check("wr_unexpected", {63'd0, wr_en}, 64'd0);
      end else begin
        check("wr_addr", wr_addr, exp_addr.pop_front());
        check("wr_data", {32'd0, wr_data}, {32'd0, exp_data.pop_front()});
      end
    end
    prev_wr_en <= wr_en;
  end

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int t;
    t = 0;
    while ($urandom_range(0, 99) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 1000) begin
      check("handshake_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_load(input string tag, input int gap_pct);
    int cyc;
    build_model();
    pulse_start();
    check({tag, "_busy_at_start"}, {63'd0, busy}, 64'd1);
    check({tag, "_done_cleared"}, {63'd0, done}, 64'd0);
    check({tag, "_hold_at_start"}, {63'd0, cpu_hold}, 64'd1);
    for (int i = 0; i < n_send; i++) send_byte(stream[i], gap_pct);
    cyc = 0;
    while (!done && !error && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_finish_timeout"}, {63'd0, cyc < 100}, 64'd1);
    check({tag, "_done"}, {63'd0, done}, {63'd0, exp_ok});
    check({tag, "_error"}, {63'd0, error}, {63'd0, !exp_ok});
    check({tag, "_cpu_hold"}, {63'd0, cpu_hold}, {63'd0, !exp_ok});
    check({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
    check({tag, "_writes_left"}, 64'(exp_addr.size()), 64'd0);
  endtask

  task automatic random_stream();
    int         n;
    logic [7:0] cs;
    logic [7:0] b;
    n  = $urandom_range(0, 8);
    cs = 8'd0;
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'd0);
    for (int i = 0; i < 4*n; i++) begin
      b  = 8'($urandom);
      cs = cs ^ b;
      stream.push_back(b);
    end
    if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(8'd1 << $urandom_range(0, 7));
    stream.push_back(cs);
  endtask

  initial begin
    logic [7:0] cs;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_hold", {63'd0, cpu_hold}, 64'd1);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_wr_addr", wr_addr, 64'd0);
    check("rst_wr_data", {32'd0, wr_data}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h91, 8'h1F, 8'h20, 8'h03, 8'hD5, 8'h6B};
    run_load("two_word", 0);

    stream[10] = 8'h6A;
    run_load("bad_csum", 0);

    stream = '{8'h01, 8'h01};
    run_load("len257", 0);

    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h01);
    cs = 8'd0;
    for (int i = 0; i < 1024; i++) begin
      b  = 8'($urandom);
      cs = cs ^ b;
      stream.push_back(b);
    end
    stream.push_back(cs);
    run_load("len256", 0);

    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h91, 8'h1F, 8'h20, 8'h03, 8'hD5, 8'h6B};
    run_load("gaps", 50);

    stream = '{8'h00, 8'h00, 8'h00};
    run_load("len0", 20);

    // Abort after the first write, two bytes into the second word.
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h91, 8'h1F, 8'h20, 8'h03, 8'hD5, 8'h6B};
    build_model();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
    check("mid_pending_writes", 64'(exp_addr.size()), 64'd1);
    reset = 1'b1;
    #1;
    exp_addr.delete();
    exp_data.delete();
    check("mid_rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_cpu_hold", {63'd0, cpu_hold}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    check("post_rst_cpu_hold", {63'd0, cpu_hold}, 64'd1);
    run_load("after_reset", 0);

    for (int k = 0; k < 8; k++) begin
      random_stream();
      run_load($sformatf("rand%0d", k), 30);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the instruction memory: a boot loader that receives a program as a byte stream and writes it word-by-word into the writable instruction RAM's write port.
- Holds the CPU in reset (cpu_hold) until a complete, checksum-verified image has been written.
- Sits between a host byte source (UART/testbench stream) and the instruction RAM; the CPU fetch side stays read-only.

Parameters:
- MEM_SIZE, 1024, instruction memory size in bytes; power of two, >4 (checked by an initial assertion).
- ADDR_W, 64, width of the write address, matching the CPU address width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; ignored while busy.
- in_valid  in  1  in_data holds a valid byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready.
- wr_en  out  1  one-cycle instruction RAM write strobe.
- wr_addr  out  ADDR_W  byte address, word-aligned.
- wr_data  out  32  instruction word.
- busy  out  1  load in progress.
- done  out  1  last load succeeded.
- error  out  1  last load failed (length or checksum).
- cpu_hold  out  1  CPU held in reset.

Behaviour:
- Stream format: LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes, little-endian per word, then 1 checksum byte. The checksum is the XOR of all data bytes; the length bytes are excluded.
- All outputs are Moore, decoded from the state register and datapath registers.
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, cpu_hold=1. State is IDLE.
- IDLE: in_ready=0. When start=1, clear word index, byte count and checksum, then go to LEN0.
- LEN0 / LEN1: in_ready=1. Each accepted byte is latched.
  - After LEN1, if N > MEM_SIZE/4, go to ERR.
  - Else if N == 0, go to CHK.
  - Otherwise go to DATA.
- DATA: in_ready=1.
  - Accepted byte k (k = 0..3) goes to wr_data[8k+7:8k], and checksum ^= byte.
  - After byte 3, go to WRITE.
- WRITE: in_ready=0, wr_en=1 for exactly one cycle, with wr_addr = word_idx*4 (upper bits zero) and wr_data = the assembled word.
  - Then word_idx increments.
  - If the new word_idx == N, go to CHK; else go to DATA.
- CHK: in_ready=1. On the accepted byte, go to DONE if it equals the checksum, else ERR.
- DONE: done=1, cpu_hold=0. start goes to LEN0, which clears done and reasserts cpu_hold.
- ERR: error=1, cpu_hold=1. start goes to LEN0, which clears error.
- busy=1 in LEN0, LEN1, DATA, WRITE and CHK; cpu_hold=1 in every state except DONE.
- Throughput: at least 5 cycles per word (4 byte cycles plus 1 write cycle). in_valid gaps stall without losing state.
- wr_addr + 3 < MEM_SIZE is guaranteed; a bench assertion checks alignment and bounds on every wr_en.
- Reset mid-load: go to IDLE immediately, with no further wr_en and cpu_hold=1. Words already written are left in RAM and are not valid until a new load reaches DONE.
- Reset has priority over start and over any in-flight handshake.

Decomposition:
- Shared package loader_pkg:
  - state enum {IDLE, LEN0, LEN1, DATA, WRITE, CHK, DONE, ERR}
  - MEM_SIZE default
  - checksum width constant
- Sub-module instr_word_assembler: 2-bit byte counter, 32-bit little-endian shift register and XOR accumulator, with clear/shift/word_full signals.
- The top level keeps the FSM, word index and length checks.

Test Plan:
- Reset -> cpu_hold=1, in_ready=0, wr_en=0, done=0, error=0, busy=0.
- start; stream 02 00 13 00 00 91 1F 20 03 D5 6B -> writes (0x0, 0x91000013) and (0x4, 0xD503201F), each a 1-cycle wr_en; then done=1, cpu_hold=0.
- Same stream with checksum 6A -> both writes occur, then error=1, done=0, cpu_hold=1.
- Length 01 01 (N=257, MEM_SIZE=1024) -> ERR after LEN1 with no wr_en. Length 00 01 (N=256) -> last write at 0x3FC, then done=1.
- Random in_valid gaps on the two-word stream -> identical writes and done=1. Length 00 00 with checksum 00 -> done=1 with no writes.
- Reset asserted after the first write, mid-DATA -> IDLE immediately, no further wr_en, cpu_hold=1. A following start with a fresh stream loads correctly and reaches done=1.
